// File: rtl/uart_tx_cfg_if.sv
// Host-side bundle for uart_tx_cfg: write strobe/data in, serial line and FIFO status out.
interface uart_tx_cfg_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             load;
  logic [15:0]      in;
  logic             clr_ovf;
  logic             TX;
  logic [15:0]      out;
  logic             tx_busy;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output load, in, clr_ovf,
    input  TX, out, tx_busy, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  load, in, clr_ovf,
    output TX, out, tx_busy, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a write FIFO; frame format (data bits, parity, stop bits)
// and bit timing are fixed by parameters.
module uart_tx_cfg #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic          CLK_100MHz,
  input logic          RST_N,
  uart_tx_cfg_if.slave tx_if
);

  localparam int unsigned BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CYC_W      = $clog2(BIT_PERIOD);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [15:0]          out_q;
  logic                 ovf_q;

  logic [2:0]           state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 full, push, pop, launch, bit_end;
  logic [DATA_BITS-1:0] head;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign push    = tx_if.load && !full;
  assign pop     = launch;
  assign head    = mem_q[rptr_q];
  assign bit_end = (cyc_q == CYC_W'(BIT_PERIOD - 1));

  // A pop on the same edge never frees a slot for a push: full is sampled pre-edge.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        out_q  <= tx_if.in;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (tx_if.load && full) begin
        ovf_q <= 1'b1;
      end else if (tx_if.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (push) begin
      mem_q[wptr_q] <= tx_if.in[DATA_BITS-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_d  = '0;
        launch = (count_q != '0);
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            launch  = (count_q != '0);
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    // Starting a frame pops the head and drives the start bit on the same edge.
    if (launch) begin
      state_d = ST_START;
      cyc_d   = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      shreg_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_if.TX         = tx_q;
  assign tx_if.out        = out_q;
  assign tx_if.tx_busy    = (state_q != ST_IDLE) || (count_q != '0);
  assign tx_if.fifo_full  = full;
  assign tx_if.fifo_count = count_q;
  assign tx_if.overflow   = ovf_q;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate; BIT_PERIOD = CLK_FREQ/BAUD_RATE (integer division), legal range >= 2.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries, power of 2, >= 2.
REQ-007 SHALL have port CLK_100MHz  input  1  the single clock; all logic on its rising edge.
REQ-008 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port load  input  1  write strobe; one push per cycle held high.
REQ-010 SHALL have port in  input  16  write word; only in[DATA_BITS-1:0] is transmitted.
REQ-011 SHALL have port clr_ovf  input  1  clears overflow flag.
REQ-012 SHALL have port TX  output  1  serial line, idle high.
REQ-013 SHALL have port out  output  16  last word accepted into the FIFO.
REQ-014 SHALL have port tx_busy  output  1  high while FIFO non-empty or a frame is in progress.
REQ-015 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-016 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-017 SHALL have port overflow  output  1  sticky: a load was dropped.

Function
REQ-018 SHALL push in[DATA_BITS-1:0] and update out<=in on a rising edge with load=1 and fifo_full=0 at that edge; a pop on the same edge does not make room for that push.
REQ-019 SHALL drop a load when fifo_full=1, leave FIFO/out unchanged, and set overflow=1 on that edge.
REQ-020 SHALL clear overflow on an edge with clr_ovf=1, unless a drop occurs on the same edge (set wins).
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transitions IDLE->START (FIFO non-empty), START->DATA, DATA->PARITY (PARITY!=0) or DATA->STOP, PARITY->STOP, STOP->START (FIFO non-empty) or STOP->IDLE.
REQ-022 SHALL pop one entry and drive TX=0 on the edge leaving IDLE or STOP; a load sampled at edge E into an empty FIFO with FSM in IDLE gives TX=0 after edge E+1.
REQ-023 SHALL hold every bit (start, each data, parity, each stop) for exactly BIT_PERIOD clocks.
REQ-024 SHALL send data LSB first, DATA_BITS bits, then parity bit (even: XOR of data bits; odd: its inverse) if enabled, then STOP_BITS bits of 1.
REQ-025 SHALL start the next frame's start bit immediately after the last stop bit period when FIFO non-empty (no idle cycle between frames).
REQ-026 SHALL keep fifo_count correct for simultaneous push and pop (count unchanged), with pointers wrapping modulo FIFO_DEPTH.
REQ-027 SHALL register TX; tx_busy SHALL fall on the edge the final stop bit completes with FIFO empty.

Reset
REQ-028 SHALL on RST_N=0, immediately and regardless of clock: TX=1, tx_busy=0, out=0, fifo_count=0, fifo_full=0, overflow=0, FSM=IDLE, bit/cycle counters=0.
REQ-029 SHALL abort any frame in progress on reset, discard FIFO contents, and transmit nothing after release until a new load.

Verification (CLK_FREQ=1000, BAUD_RATE=100, BIT_PERIOD=10)
REQ-030 SHALL verify 8N1, load in=0x0055 -> TX 0,1,0,1,0,1,0,1,0,1 each 10 cycles, start 1 edge after push; tx_busy low after 100 cycles.
REQ-031 SHALL verify 8E1 in=0x0007 -> parity bit 1, frame 110 cycles; 8O1 same data -> parity bit 0.
REQ-032 SHALL verify 7N2 in=0x00FF -> 7 data ones then 2 stop bits, frame 100 cycles, in[7] not sent.
REQ-033 SHALL verify FIFO_DEPTH=4, 5 consecutive loads 0x01..0x05 while idle -> 0x01 popped after first push so 0x05 accepted, then 6th load 0x06 dropped, overflow=1; 5 frames back-to-back, no idle gap; clr_ovf pulse -> overflow=0.
REQ-034 SHALL verify load while fifo_full=1 on the same edge as a pop -> word dropped, fifo_count decrements by 1, overflow=1.
REQ-035 SHALL verify RST_N low during data bit 3 of frame with 2 words queued -> TX=1 same cycle, fifo_count=0, no TX activity for 200 cycles after release.
